alarmclock_cpu_debug_ocimem: RTL and testbench

JTAG-to-memory command engine and debug-RAM owner for the AlarmClock Nios II debug core. Sits directly downstream of the debug-slave wrapper's system-clock side and consumes its `jdo` word and `take_action_ocimem_*` / `take_no_action_ocimem_a` pulses. Executes JTAG address-load, read and write commands against an internal DEPTH x 32 debug RAM, returning read data on `MonDReg`. Also arbitrates a CPU-side Avalon-MM slave port onto the same RAM.

---
 rtl/alarmclock_cpu_debug_ocimem.sv | 187 ++++++++++++++++++
 tb/tb_alarmclock_cpu_debug_ocimem.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarmclock_cpu_debug_ocimem.sv
`timescale 1ns/1ps
// alarmclock_cpu_debug_ocimem
//
// JTAG-to-memory command engine and owner of the DEPTH x 32 debug RAM for
// the AlarmClock Nios II debug core. It executes address-load, read and
// write commands that arrive as one-cycle take_* pulses from the
// debug-slave wrapper. It also arbitrates a CPU-side Avalon-MM slave onto
// the same RAM. JTAG always wins over the CPU in the same cycle.
//
// Ports
//   clk, reset_n                 system clock, async active-low reset
//   jdo[37:0]                    JTAG data word
//   take_action_ocimem_a         load MonAReg from jdo[25+ADDR_W:26]; read if jdo[17]
//   take_action_ocimem_b         write jdo[34:3] to RAM[MonAReg], post-increment
//   take_no_action_ocimem_a      read RAM[MonAReg] into MonDReg, post-increment
//   MonDReg[31:0]                last JTAG read data
//   MonAReg[ADDR_W-1:0]          current JTAG word address
//   mon_busy                     JTAG command in flight or pending
//   cmd_overrun                  sticky: a JTAG command was dropped
//   address, chipselect, read, write, writedata, byteenable   CPU Avalon inputs
//   readdata[31:0], waitrequest  CPU Avalon outputs (waitrequest is combinational)
module alarmclock_cpu_debug_ocimem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              mon_busy,
  output logic              cmd_overrun,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              waitrequest
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_J_RD  = 3'd1;
  localparam logic [2:0] S_J_CAP = 3'd2;
  localparam logic [2:0] S_J_WR  = 3'd3;
  localparam logic [2:0] S_C_RD  = 3'd4;

  localparam logic [1:0] CMD_LOAD = 2'd0;
  localparam logic [1:0] CMD_WR   = 2'd1;
  localparam logic [1:0] CMD_RD   = 2'd2;

  logic [2:0]        state;
  logic              pend_full;
  logic [1:0]        pend_cmd;
  logic [37:0]       pend_jdo;
  logic [31:0]       wr_data;
  logic              inc_after;
  logic [31:0]       ram_q;
  logic [31:0]       mem [DEPTH];

  logic              in_idle;
  logic              new_pulse;
  logic [1:0]        new_cmd;
  logic              jtag_take;
  logic [1:0]        take_cmd;
  logic [37:0]       take_jdo;
  logic [ADDR_W-1:0] load_addr;
  logic              cpu_wr_go;
  logic              cpu_rd_go;
  logic              cpu_rd_done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              pend_load;
  logic              unused_jdo_bits;

  always_comb begin
    in_idle   = (state == S_IDLE);
    new_pulse = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    // Pulses should be exclusive; if not, a > b > no_action.
    if (take_action_ocimem_a)      new_cmd = CMD_LOAD;
    else if (take_action_ocimem_b) new_cmd = CMD_WR;
    else                           new_cmd = CMD_RD;

    // A pending command is older than any pulse arriving now, so it goes first.
    jtag_take = in_idle & (pend_full | new_pulse);
    take_cmd  = pend_full ? pend_cmd : new_cmd;
    take_jdo  = pend_full ? pend_jdo : jdo;
    load_addr = take_jdo[25+ADDR_W:26];

    cpu_wr_go   = in_idle & ~jtag_take & chipselect & write;
    cpu_rd_go   = in_idle & ~jtag_take & chipselect & read & ~write;
    cpu_rd_done = (state == S_C_RD);
    waitrequest = chipselect & (read | write) & ~(cpu_wr_go | cpu_rd_done);
    readdata    = ram_q;

    mon_busy = pend_full | (state == S_J_RD) | (state == S_J_CAP) | (state == S_J_WR);

    rd_en   = (state == S_J_RD) | cpu_rd_go;
    rd_addr = (state == S_J_RD) ? MonAReg : address;

    // Pending slot refills when in IDLE (old entry leaves as the new one
    // arrives) or when busy with an empty slot.
    pend_load = new_pulse & (in_idle ? pend_full : ~pend_full);

    unused_jdo_bits = ^{take_jdo[37:35], take_jdo[2:0]};
  end

  // Control: FSM, JTAG registers, pending flag, overrun, RAM output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      MonDReg     <= '0;
      MonAReg     <= '0;
      pend_full   <= 1'b0;
      cmd_overrun <= 1'b0;
      ram_q       <= '0;
    end else begin
      if (rd_en) ram_q <= mem[rd_addr];

      if (in_idle) begin
        if (pend_full && !new_pulse) pend_full <= 1'b0;
      end else if (new_pulse) begin
        if (pend_full) cmd_overrun <= 1'b1;
        else           pend_full   <= 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          if (jtag_take) begin
            unique case (take_cmd)
              CMD_LOAD: begin
                MonAReg <= load_addr;
                if (take_jdo[17]) state <= S_J_RD;
              end
              CMD_WR:   state <= S_J_WR;
              default:  state <= S_J_RD;
            endcase
          end else if (cpu_rd_go) begin
            state <= S_C_RD;
          end
        end
        S_J_RD:  state <= S_J_CAP;
        S_J_CAP: begin
          MonDReg <= ram_q;
          if (inc_after) MonAReg <= MonAReg + ADDR_ONE;
          state <= S_IDLE;
        end
        S_J_WR: begin
          MonAReg <= MonAReg + ADDR_ONE;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Command payload registers (data only, no reset)
  always_ff @(posedge clk) begin
    if (pend_load) begin
      pend_cmd <= new_cmd;
      pend_jdo <= jdo;
    end
    if (jtag_take) begin
      wr_data   <= take_jdo[34:3];
      inc_after <= (take_cmd == CMD_RD);
    end
  end

  // Debug RAM write port; the async reset forces state to IDLE, which
  // suppresses a J_WR write at the next edge.
  always_ff @(posedge clk) begin
    if (state == S_J_WR) begin
      mem[MonAReg] <= wr_data;
    end else if (cpu_wr_go) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_alarmclock_cpu_debug_ocimem.sv
`timescale 1ns/1ps
module tb_alarmclock_cpu_debug_ocimem;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic [31:0]       MonDReg;
  logic [ADDR_W-1:0] MonAReg;
  logic              mon_busy;
  logic              cmd_overrun;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              waitrequest;

  always #5 clk = ~clk;

  alarmclock_cpu_debug_ocimem #(.ADDR_W(ADDR_W)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .mon_busy                (mon_busy),
    .cmd_overrun             (cmd_overrun),
    .address                 (address),
    .chipselect              (chipselect),
    .read                    (read),
    .write                   (write),
    .writedata               (writedata),
    .byteenable              (byteenable),
    .readdata                (readdata),
    .waitrequest             (waitrequest)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] mdl [256];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL sb_empty: got %08h expected none queued", got);
    end else begin
      e = exp_q.pop_front();
      check_val(e.tag, got, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_load(input logic [7:0] a, input logic rd);
    logic [37:0] j;
    j = '0;
    j[33:26] = a;
    j[17] = rd;
    return j;
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // kind: 0 = load (a), 1 = write (b), 2 = read (no_action_a). Returns at T+1.
  task automatic jtag(input int kind, input logic [37:0] j);
    jdo = j;
    take_action_ocimem_a    = (kind == 0);
    take_action_ocimem_b    = (kind == 1);
    take_no_action_ocimem_a = (kind == 2);
    tick();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_write_at(input logic [7:0] a, input logic [31:0] d);
    jtag(0, jdo_load(a, 1'b0));
    jtag(1, jdo_data(d));
    mdl[a] = d;
    tick();
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (mon_busy && n < max_cyc) begin
      tick();
      n++;
    end
    if (mon_busy) check_val("idle_timeout", {31'b0, mon_busy}, 32'h0);
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    byteenable = be;
    #1;
    check_val("cpu_wr_wait", {31'b0, waitrequest}, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) if (be[i]) mdl[a][i*8 +: 8] = d[i*8 +: 8];
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  // Issues a CPU read and returns the number of stalled cycles seen.
  task automatic cpu_read(input logic [7:0] a, output int stalls);
    sb_push("cpu_rd_data", mdl[a]);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    stalls     = 0;
    #1;
    while (waitrequest && stalls < 8) begin
      tick();
      stalls++;
    end
    if (waitrequest) check_val("cpu_rd_timeout", {31'b0, waitrequest}, 32'h0);
    sb_pop(readdata);
    tick();
    chipselect = 1'b0;
    read       = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_mondreg"},  MonDReg, 32'h0);
    check_val({pfx, "_monareg"},  {24'b0, MonAReg}, 32'h0);
    check_val({pfx, "_busy"},     {31'b0, mon_busy}, 32'h0);
    check_val({pfx, "_overrun"},  {31'b0, cmd_overrun}, 32'h0);
    check_val({pfx, "_readdata"}, readdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    address = '0;
    chipselect = 1'b0;
    read = 1'b0;
    write = 1'b0;
    writedata = '0;
    byteenable = '0;
    tick();
    tick();
    check_reset_outputs("rst");
    check_val("rst_wait", {31'b0, waitrequest}, 32'h0);
    reset_n = 1'b1;
    tick();

    // Load 0x10, write 0xDEADBEEF, load+read 0x10
    jtag(0, jdo_load(8'h10, 1'b0));
    check_val("load_areg", {24'b0, MonAReg}, 32'h10);
    check_val("load_busy", {31'b0, mon_busy}, 32'h0);
    jtag(1, jdo_data(32'hDEADBEEF));
    mdl[8'h10] = 32'hDEADBEEF;
    check_val("wr_busy_t1", {31'b0, mon_busy}, 32'h1);
    tick();
    check_val("wr_areg_inc", {24'b0, MonAReg}, 32'h11);
    check_val("wr_busy_t2", {31'b0, mon_busy}, 32'h0);
    sb_push("ldrd_mondreg", mdl[8'h10]);
    jtag(0, jdo_load(8'h10, 1'b1));
    check_val("ldrd_areg_t1", {24'b0, MonAReg}, 32'h10);
    check_val("ldrd_busy_t1", {31'b0, mon_busy}, 32'h1);
    tick();
    check_val("ldrd_busy_t2", {31'b0, mon_busy}, 32'h1);
    tick();
    sb_pop(MonDReg);
    check_val("ldrd_areg_t3", {24'b0, MonAReg}, 32'h10);
    check_val("ldrd_busy_t3", {31'b0, mon_busy}, 32'h0);

    // Address wrap on write and on read at 0xFF
    jtag_write_at(8'hFF, 32'hCAFEF00D);
    check_val("wr_wrap_areg", {24'b0, MonAReg}, 32'h0);
    jtag(0, jdo_load(8'hFF, 1'b0));
    sb_push("rd_wrap_mondreg", mdl[8'hFF]);
    jtag(2, '0);
    tick();
    tick();
    sb_pop(MonDReg);
    check_val("rd_wrap_areg", {24'b0, MonAReg}, 32'h0);

    // CPU byte-lane write then read
    cpu_write(8'd5, 32'hFFFFFFFF, 4'b1111);
    cpu_write(8'd5, 32'h12345678, 4'b0011);
    check_val("model_merge", mdl[5], 32'hFFFF5678);
    cpu_read(8'd5, stalls);
    check_val("cpu_rd_stalls", stalls, 32'd1);

    // CPU read colliding with a JTAG write at MonAReg = 0
    sb_push("coll_cpu_rd", mdl[5]);
    chipselect = 1'b1;
    read = 1'b1;
    address = 8'd5;
    jdo = jdo_data(32'hA5A50001);
    take_action_ocimem_b = 1'b1;
    #1;
    check_val("coll_wait_t0", {31'b0, waitrequest}, 32'h1);
    tick();
    take_action_ocimem_b = 1'b0;
    mdl[0] = 32'hA5A50001;
    check_val("coll_wait_jwr", {31'b0, waitrequest}, 32'h1);
    check_val("coll_busy_jwr", {31'b0, mon_busy}, 32'h1);
    tick();
    check_val("coll_wait_idle", {31'b0, waitrequest}, 32'h1);
    check_val("coll_areg", {24'b0, MonAReg}, 32'h1);
    tick();
    check_val("coll_wait_crd", {31'b0, waitrequest}, 32'h0);
    sb_pop(readdata);
    tick();
    chipselect = 1'b0;
    read = 1'b0;
    sb_push("coll_jtag_word", mdl[0]);
    jtag(0, jdo_load(8'h00, 1'b1));
    tick();
    tick();
    sb_pop(MonDReg);

    // Three back-to-back reads: execute, pend, drop
    jtag_write_at(8'h20, 32'h11112020);
    jtag_write_at(8'h21, 32'h21212121);
    jtag(0, jdo_load(8'h20, 1'b0));
    sb_push("b2b_first", mdl[8'h20]);
    sb_push("b2b_second", mdl[8'h21]);
    take_no_action_ocimem_a = 1'b1;
    tick();
    tick();
    tick();
    take_no_action_ocimem_a = 1'b0;
    sb_pop(MonDReg);
    check_val("b2b_areg_mid", {24'b0, MonAReg}, 32'h21);
    check_val("b2b_overrun", {31'b0, cmd_overrun}, 32'h1);
    wait_idle(20);
    sb_pop(MonDReg);
    check_val("b2b_areg_end", {24'b0, MonAReg}, 32'h22);
    check_val("b2b_overrun_sticky", {31'b0, cmd_overrun}, 32'h1);

    // Reset during J_WR leaves the target word intact
    jtag_write_at(8'h30, 32'h30303030);
    jtag(0, jdo_load(8'h30, 1'b0));
    jtag(1, jdo_data(32'h55555555));
    check_val("rstwr_busy", {31'b0, mon_busy}, 32'h1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rstwr");
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    cpu_read(8'h30, stalls);
    check_val("rstwr_cpu_stalls", stalls, 32'd1);
    sb_push("rstwr_jtag_word", mdl[8'h30]);
    jtag(0, jdo_load(8'h30, 1'b1));
    tick();
    tick();
    sb_pop(MonDReg);

    check_val("sb_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
